// File: rtl/unpacked_mxint_block_accumulator.sv
// +----------------------------------------------------------------------------+
// | Module  : unpacked_mxint_block_accumulator                                 |
// | Purpose : Element-wise accumulation of BLOCK_COUNT MXINT beats into one    |
// |           wider MXINT block, aligned to the running maximum exponent.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module unpacked_mxint_block_accumulator #(
   parameter  int BLOCK_SIZE  = 4,
   parameter  int MAN_WIDTH   = 8,
   parameter  int EXP_WIDTH   = 8,
   parameter  int BLOCK_COUNT = 4,
   localparam int OUT_WIDTH   = MAN_WIDTH + $clog2(BLOCK_COUNT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE],
   input  logic [EXP_WIDTH-1:0] edata_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic [OUT_WIDTH-1:0] mdata_out [BLOCK_SIZE],
   output logic [EXP_WIDTH-1:0] edata_out,
   output logic                 data_out_valid,
   input  logic                 data_out_ready
);

   localparam int               C_CNT_W  = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;
   localparam int               C_DIFF_W = EXP_WIDTH + 1;
   localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(BLOCK_COUNT - 1);

   // Arithmetic right shift; amounts at or beyond the word width give pure sign.
   function automatic logic signed [OUT_WIDTH-1:0] asr(
      input logic signed [OUT_WIDTH-1:0] x,
      input logic [C_DIFF_W-1:0]         amt
   );
      if (amt >= C_DIFF_W'(OUT_WIDTH))
         return {OUT_WIDTH{x[OUT_WIDTH-1]}};
      else
         return x >>> amt;
   endfunction

   logic [C_CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [OUT_WIDTH-1:0] acc_q [BLOCK_SIZE];
   logic signed [OUT_WIDTH-1:0] acc_d [BLOCK_SIZE];
   logic [EXP_WIDTH-1:0]        acc_e_q, acc_e_d;
   logic [OUT_WIDTH-1:0]        mout_q [BLOCK_SIZE];
   logic [OUT_WIDTH-1:0]        mout_d [BLOCK_SIZE];
   logic [EXP_WIDTH-1:0]        eout_q, eout_d;
   logic                        vout_q, vout_d;

   logic                        w_accept;
   logic                        w_first;
   logic                        w_last;
   logic                        w_rise;
   logic signed [C_DIFF_W-1:0]  w_diff;
   logic [C_DIFF_W-1:0]         w_neg_diff;
   logic signed [OUT_WIDTH-1:0] w_ext [BLOCK_SIZE];
   logic signed [OUT_WIDTH-1:0] w_sum [BLOCK_SIZE];
   logic [EXP_WIDTH-1:0]        w_sum_e;

   assign data_in_ready = rst & (~vout_q | data_out_ready);
   assign w_accept      = data_in_valid & data_in_ready;
   assign w_first       = (cnt_q == '0);
   assign w_last        = (cnt_q == C_LAST_CNT);

   always_comb begin
      w_diff     = $signed({edata_in[EXP_WIDTH-1], edata_in}) -
                   $signed({acc_e_q[EXP_WIDTH-1], acc_e_q});
      w_neg_diff = $unsigned(-w_diff);
      w_rise     = ~w_diff[C_DIFF_W-1] & (w_diff != '0);
      w_sum_e    = (w_first | w_rise) ? edata_in : acc_e_q;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         w_ext[i] = OUT_WIDTH'($signed(mdata_in[i]));
         w_sum[i] = w_ext[i];
         if (!w_first) begin
            if (w_rise)
               w_sum[i] = asr(acc_q[i], $unsigned(w_diff)) + w_ext[i];
            else
               w_sum[i] = acc_q[i] + asr(w_ext[i], w_neg_diff);
         end
      end
   end

   // The final beat bypasses the accumulator and lands in the output register.
   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      acc_e_d = acc_e_q;
      mout_d  = mout_q;
      eout_d  = eout_q;
      vout_d  = vout_q;
      if (data_out_ready)
         vout_d = 1'b0;
      if (w_accept) begin
         if (w_last) begin
            for (int i = 0; i < BLOCK_SIZE; i++)
               mout_d[i] = w_sum[i];
            eout_d = w_sum_e;
            vout_d = 1'b1;
            cnt_d  = '0;
         end else begin
            acc_d   = w_sum;
            acc_e_d = w_sum_e;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         acc_e_q <= '0;
         eout_q  <= '0;
         vout_q  <= 1'b0;
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            acc_q[i]  <= '0;
            mout_q[i] <= '0;
         end
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         acc_e_q <= acc_e_d;
         mout_q  <= mout_d;
         eout_q  <= eout_d;
         vout_q  <= vout_d;
      end
   end

   assign mdata_out      = mout_q;
   assign edata_out      = eout_q;
   assign data_out_valid = vout_q;

endmodule

`default_nettype wire

// File: tb/tb_unpacked_mxint_block_accumulator.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_unpacked_mxint_block_accumulator                              |
// | Purpose : Directed and randomized checks against an integer block model.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_unpacked_mxint_block_accumulator;

   localparam int BS = 2;
   localparam int MW = 8;
   localparam int EW = 8;
   localparam int BC = 4;
   localparam int OW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [MW-1:0] mdata_in [BS];
   logic [EW-1:0] edata_in;
   logic          data_in_valid;
   logic          data_in_ready;
   logic [OW-1:0] mdata_out [BS];
   logic [EW-1:0] edata_out;
   logic          data_out_valid;
   logic          data_out_ready;

   unpacked_mxint_block_accumulator #(
      .BLOCK_SIZE (BS),
      .MAN_WIDTH  (MW),
      .EXP_WIDTH  (EW),
      .BLOCK_COUNT(BC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mdata_in      (mdata_in),
      .edata_in      (edata_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .mdata_out     (mdata_out),
      .edata_out     (edata_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: exact integer arithmetic on whole blocks.
   typedef struct { int m0; int m1; int e; } res_t;
   res_t exp_q[$];
   int   m_cnt;
   int   m_acc [BS];
   int   m_e;

   function automatic int ref_shift(input int x, input int k);
      if (k >= OW) return (x < 0) ? -1 : 0;
      return x >>> k;
   endfunction

   task automatic model_beat(input int m0, input int m1, input int e);
      int   mv [BS];
      int   d;
      res_t r;
      mv[0] = m0;
      mv[1] = m1;
      if (m_cnt == 0) begin
         for (int i = 0; i < BS; i++) m_acc[i] = mv[i];
         m_e = e;
      end else begin
         d = e - m_e;
         if (d > 0) begin
            for (int i = 0; i < BS; i++) m_acc[i] = ref_shift(m_acc[i], d) + mv[i];
            m_e = e;
         end else begin
            for (int i = 0; i < BS; i++) m_acc[i] = m_acc[i] + ref_shift(mv[i], -d);
         end
      end
      m_cnt++;
      if (m_cnt == BC) begin
         r.m0 = m_acc[0];
         r.m1 = m_acc[1];
         r.e  = m_e;
         exp_q.push_back(r);
         m_cnt = 0;
      end
   endtask

   // Entered at a falling edge; returns one cycle later at the next falling edge.
   task automatic drive(input bit v, input int m0, input int m1, input int e, input bit rdy,
                        output logic hin, output logic hout, output logic [27:0] snap);
      data_in_valid  = v;
      mdata_in[0]    = 8'(m0);
      mdata_in[1]    = 8'(m1);
      edata_in       = 8'(e);
      data_out_ready = rdy;
      #1;
      hin  = v && data_in_ready;
      hout = data_out_valid && data_out_ready;
      snap = {mdata_out[0], mdata_out[1], edata_out};
      if (hin) model_beat(m0, m1, e);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      data_in_valid = 1'b0;
      @(negedge clk);
      rst   = 1'b1;
      m_cnt = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst            = 1'b0;
      data_in_valid  = 1'b0;
      data_out_ready = 1'b1;
      mdata_in[0]    = '0;
      mdata_in[1]    = '0;
      edata_in       = '0;
      #1;
      total++;
      if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out, data_in_ready} !== 30'd0) begin
         bad++;
         $display("FAIL reset_state: got v=%b m=%h,%h e=%h rdy=%b want all zero",
                  data_out_valid, mdata_out[0], mdata_out[1], edata_out, data_in_ready);
      end
      @(negedge clk);
      rst   = 1'b1;
      m_cnt = 0;
      @(negedge clk);
      total++;
      if (data_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b want 1", data_in_ready);
      end
   endtask

   task automatic test_equal_exp();
      logic hi, ho;
      logic [27:0] sn;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, -2, 3, 1, hi, ho, sn);
         total++;
         if (hi !== 1'b1 || (k < 3 && data_out_valid !== 1'b0)) begin
            bad++;
            $display("FAIL eq_beat%0d: got accept=%b valid=%b want 1 and valid only after beat 4",
                     k, hi, data_out_valid);
         end
      end
      total++;
      if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(4), 10'(-8), 8'(3)}) begin
         bad++;
         $display("FAIL eq_result: got v=%b m=%0d,%0d e=%0d want 1 4,-8 3", data_out_valid,
                  $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
      end
      drive(0, 0, 0, 0, 1, hi, ho, sn);
      total++;
      if (data_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL eq_valid_clear: got %b want 0", data_out_valid);
      end
   endtask

   task automatic run_four(input int b0m0, input int b0m1, input int b0e,
                           input int b1m0, input int b1m1, input int b1e,
                           input int b2e, input int b3e);
      logic hi, ho;
      logic [27:0] sn;
      drive(1, b0m0, b0m1, b0e, 1, hi, ho, sn);
      drive(1, b1m0, b1m1, b1e, 1, hi, ho, sn);
      drive(1, 0, 0, b2e, 1, hi, ho, sn);
      drive(1, 0, 0, b3e, 1, hi, ho, sn);
   endtask

   task automatic test_rising();
      do_reset();
      run_four(64, 64, 0, 1, 1, 2, 0, 0);
      total++;
      if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(17), 10'(17), 8'(2)}) begin
         bad++;
         $display("FAIL rising_exp: got m=%0d,%0d e=%0d want 17,17 2",
                  $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
      end
   endtask

   task automatic test_falling();
      do_reset();
      run_four(8, -8, 5, 8, -1, 3, 5, 5);
      total++;
      if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(10), 10'(-9), 8'(5)}) begin
         bad++;
         $display("FAIL falling_exp: got m=%0d,%0d e=%0d want 10,-9 5",
                  $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
      end
   endtask

   task automatic test_large_shift();
      do_reset();
      run_four(-128, 127, -100, 1, 1, 100, 100, 100);
      total++;
      if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(0), 10'(1), 8'(100)}) begin
         bad++;
         $display("FAIL large_shift: got m=%0d,%0d e=%0d want 0,1 100",
                  $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
      end
   endtask

   task automatic test_back_to_back();
      logic hi, ho;
      logic [27:0] sn;
      do_reset();
      for (int k = 0; k < 4; k++) drive(1, 2, -2, 7, 0, hi, ho, sn);
      for (int k = 0; k < 5; k++) begin
         drive(1, 9, 9, 1, 0, hi, ho, sn);
         total++;
         if (hi !== 1'b0 || data_in_ready !== 1'b0 ||
             {data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(8), 10'(-8), 8'(7)}) begin
            bad++;
            $display("FAIL bp_hold%0d: got acc=%b rdy=%b v=%b m=%0d,%0d e=%0d want 0 0 1 8,-8 7", k, hi,
                     data_in_ready, data_out_valid, $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
         end
      end
      for (int k = 0; k < 8; k++) begin
         if (k < 4) drive(1, 1, 2, 0, 1, hi, ho, sn);
         else       drive(1, -3, 5, 1, 1, hi, ho, sn);
         total++;
         if (hi !== 1'b1 || ((k == 0 || k == 4) && ho !== 1'b1)) begin
            bad++;
            $display("FAIL b2b_beat%0d: got accept=%b out_hs=%b want 1 1", k, hi, ho);
         end
         if (k == 3) begin
            total++;
            if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(4), 10'(8), 8'(0)}) begin
               bad++;
               $display("FAIL b2b_block1: got m=%0d,%0d e=%0d want 4,8 0",
                        $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
            end
         end
         if (k == 4) begin
            total++;
            if (data_out_valid !== 1'b0) begin
               bad++;
               $display("FAIL b2b_valid_drop: got %b want 0", data_out_valid);
            end
         end
      end
      total++;
      if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(-12), 10'(20), 8'(1)}) begin
         bad++;
         $display("FAIL b2b_block2: got m=%0d,%0d e=%0d want -12,20 1",
                  $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
      end
   endtask

   task automatic test_reset_mid_block();
      logic hi, ho;
      logic [27:0] sn;
      do_reset();
      for (int k = 0; k < 4; k++) drive(1, 3, 3, 0, 1, hi, ho, sn);
      drive(0, 0, 0, 0, 0, hi, ho, sn);
      for (int r = 0; r < 2; r++) begin
         if (r == 1) for (int k = 0; k < 2; k++) drive(1, 5, 5, 0, 1, hi, ho, sn);
         rst            = 1'b0;
         data_out_ready = 1'b1;
         data_in_valid  = 1'b1;
         #1;
         total++;
         if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out, data_in_ready} !== 30'd0) begin
            bad++;
            $display("FAIL rst_mid%0d: got v=%b m=%h,%h e=%h rdy=%b want all zero", r,
                     data_out_valid, mdata_out[0], mdata_out[1], edata_out, data_in_ready);
         end
         @(negedge clk);
         rst   = 1'b1;
         m_cnt = 0;
         exp_q.delete();
      end
      for (int k = 0; k < 4; k++) drive(1, 1, 1, 0, 1, hi, ho, sn);
      total++;
      if ({data_out_valid, mdata_out[0], mdata_out[1], edata_out} !== {1'b1, 10'(4), 10'(4), 8'(0)}) begin
         bad++;
         $display("FAIL rst_mid_result: got m=%0d,%0d e=%0d want 4,4 0",
                  $signed(mdata_out[0]), $signed(mdata_out[1]), $signed(edata_out));
      end
   endtask

   task automatic test_random();
      logic hi, ho;
      logic [27:0] sn;
      res_t x;
      bit   v, rdy, wide;
      int   e;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         v    = ($urandom_range(0, 9) < 7);
         rdy  = (c >= 590) ? 1'b1 : ($urandom_range(0, 9) < 7);
         wide = ($urandom_range(0, 9) < 2);
         e    = wide ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 8)) - 4;
         if (c >= 590) v = 1'b0;
         drive(v, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, e, rdy, hi, ho, sn);
         if (ho) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rnd_unexpected: got result %h at cycle %0d want none", sn, c);
            end else begin
               x = exp_q.pop_front();
               if (sn !== {10'(x.m0), 10'(x.m1), 8'(x.e)}) begin
                  bad++;
                  $display("FAIL rnd_result: got %h want %h at cycle %0d", sn,
                           {10'(x.m0), 10'(x.m1), 8'(x.e)}, c);
               end
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rnd_drain: got %0d results missing want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_equal_exp();
      test_rising();
      test_falling();
      test_large_shift();
      test_back_to_back();
      test_reset_mid_block();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/unpacked_mxint_block_accumulator.md
# unpacked_mxint_block_accumulator

Accumulates BLOCK_COUNT consecutive MXINT beats element-wise into one wider MXINT block. Each beat is BLOCK_SIZE mantissas plus one shared exponent. Alignment is to the running maximum exponent. The block sits directly downstream of the unpacked repeat circular buffer and the per-beat MXINT multipliers in the ViT block, and reduces partial-product blocks to one result per BLOCK_COUNT input beats.

## Interface
- BLOCK_SIZE, 4: mantissas per beat.
- MAN_WIDTH, 8: input mantissa width, signed two's complement.
- EXP_WIDTH, 8: shared exponent width, signed.
- BLOCK_COUNT, 4: beats accumulated per output (≥1).
- OUT_WIDTH, MAN_WIDTH+$clog2(BLOCK_COUNT): output mantissa width. Derived; do not override.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; deassert is synchronous to clk.
- mdata_in  in  [MAN_WIDTH-1:0] x BLOCK_SIZE (unpacked)  input mantissas.
- edata_in  in  EXP_WIDTH  input shared exponent.
- data_in_valid  in  1  input beat valid.
- data_in_ready  out  1  input beat accepted when valid&&ready.
- mdata_out  out  [OUT_WIDTH-1:0] x BLOCK_SIZE (unpacked)  accumulated mantissas.
- edata_out  out  EXP_WIDTH  result shared exponent.
- data_out_valid  out  1  result valid.
- data_out_ready  in  1  result consumed when valid&&ready.

## Operation
- State:
  - beat counter cnt, range 0..BLOCK_COUNT-1.
  - accumulator acc[BLOCK_SIZE] of OUT_WIDTH bits, plus running exponent acc_e.
  - output register (mdata_out/edata_out/data_out_valid), separate from the accumulator.
- Accepted beat with cnt==0: acc = sign-extended mdata_in; acc_e = edata_in.
- Accepted beat with cnt>0:
  - Compute d = edata_in − acc_e as a signed EXP_WIDTH+1-bit value.
  - If d>0: acc = (acc >>> d) + ext(mdata_in); acc_e = edata_in.
  - If d≤0: acc = acc + (ext(mdata_in) >>> −d); acc_e unchanged.
- Shift rules:
  - Arithmetic right shift; truncates toward −inf.
  - A shift amount ≥ OUT_WIDTH yields all sign bits (0 or −1).
  - Equal exponents: no shift.
- Addition does not saturate. OUT_WIDTH is sized so BLOCK_COUNT aligned terms cannot overflow.
- Accepted beat with cnt==BLOCK_COUNT-1:
  - The final sum (same formula) is written directly to the output register, with data_out_valid=1.
  - cnt returns to 0. The accumulator is free for the next block.
- BLOCK_COUNT==1: every accepted beat goes straight to the output register, sign-extended.
- Output register is held stable while data_out_valid && !data_out_ready.
- data_out_valid clears on the handshake unless a new final beat is accepted in the same cycle.

## Timing
- Reset (rst=0), asynchronous, all of the following immediately:
  - data_out_valid=0, mdata_out=0, edata_out=0.
  - cnt=0, acc=0, acc_e=0.
  - data_in_ready=0 while rst is asserted.
- Reset mid-block discards the partial sum. The first beat after reset starts a new block.
- data_in_ready = !data_out_valid || data_out_ready.
  - This is combinational and independent of data_in_valid.
  - It applies to all beats, not just final ones. This keeps the control simple, and block order is preserved.
- Throughput: one beat per cycle, sustained, when data_out_ready=1.
- Latency: data_out_valid rises the cycle after the final beat's handshake.
- Simultaneous output handshake and final-beat acceptance in one cycle: the new result replaces the old one and data_out_valid stays 1. No bubble, no loss.
- Simultaneous output handshake and non-final beat: data_out_valid→0 and the accumulator updates.
- No combinational path from data_in_* to data_out_*. The only combinational path is data_out_ready→data_in_ready.
- Input values are sampled only on handshake cycles. Values while !data_in_valid are ignored.

## Test plan
Configuration for all scenarios: BLOCK_SIZE=2, MAN_WIDTH=8, EXP_WIDTH=8, BLOCK_COUNT=4, OUT_WIDTH=10.

- Equal exponents:
  - Stimulus: 4 back-to-back beats of m={1,−2}, e=3, with data_out_ready=1.
  - Required: mdata_out={4,−8}, edata_out=3, valid exactly 1 cycle after the 4th handshake.
- Rising exponent:
  - Stimulus: beats ({64,64},e=0), ({1,1},e=2), ({0,0},e=0), ({0,0},e=0).
  - Required: out {17,17}, e=2. Checks acc shift 64>>>2=16.
- Falling exponent and negative truncation:
  - Stimulus: ({8,−8},e=5), ({8,−1},e=3), then two ({0,0},e=5).
  - Required: out {10,−9}, e=5. Checks −1>>>2 = −1.
- Large shift:
  - Stimulus: ({−128,127},e=−100), ({1,1},e=100), then two ({0,0},e=100).
  - Required: out {0,1}, e=100. Checks d=200 exceeds EXP_WIDTH and saturates acc to {−1,0}.
- Backpressure:
  - Stimulus: complete a block with data_out_ready=0 for 5 cycles.
  - Required: outputs stable and data_in_ready=0 for those cycles, no beat accepted.
  - Then raise data_out_ready with data_in_valid=1: result and input transfer in the same cycle, and 2 full blocks run back-to-back with no idle cycles.
- Reset mid-block:
  - Stimulus: accept 2 beats of ({5,5},e=0), assert rst for 1 cycle, then 4 beats of ({1,1},e=0).
  - Required: all outputs 0 during reset; first result {4,4}, e=0.
